// File: rtl/pps_pkg.sv
// Shared types and defaults for the PPS-locked pulse-train generator.
// State encoding is visible on o_state, so keep the values fixed.
package pps_pkg;

    localparam int PPS_CNT_W = 32;
    localparam int PPS_NUM_W = 16;
    localparam int PPS_WD_W  = 32;
    localparam int PPS_SYNC  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pps_state_t;

endpackage

// File: rtl/pps_edge_det.sv
// PPS input synchroniser with registered rising-edge detect.
// Edges are only accepted after a genuine synchronised low has been seen.
module pps_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sync,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_sync_d;
    logic                   r_armed;
    logic                   r_edge;
    logic                   w_sync_q;
    logic                   w_rise;

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync_q & ~r_sync_d & r_armed;
    assign o_edge   = r_edge;

    // r_vld marks when the chain holds real samples rather than reset zeros
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_vld    <= '0;
            r_sync_d <= 1'b0;
            r_armed  <= 1'b0;
            r_edge   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_sync};
            r_vld    <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_sync_d <= w_sync_q;
            if (r_vld[SYNC_STAGES-1] && !w_sync_q)
                r_armed <= 1'b1;
            r_edge   <= w_rise;
        end
    end

endmodule

// File: rtl/pps_pulse_gen.sv
// PPS-triggered burst generator: N pulses of programmable half-period,
// restartable by a new edge, with watchdog-driven holdover.
module pps_pulse_gen
    import pps_pkg::*;
#(
    parameter int CNT_W       = PPS_CNT_W,
    parameter int NUM_W       = PPS_NUM_W,
    parameter int SYNC_STAGES = PPS_SYNC,
    parameter int WD_W        = PPS_WD_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sync,
    input  logic [NUM_W-1:0] i_pulse_num,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic [WD_W-1:0]  i_timeout,
    input  logic             i_holdover_en,
    output logic             o_trig,
    output logic             o_trig_stb,
    output logic [NUM_W-1:0] o_pulse_idx,
    output logic             o_busy,
    output logic             o_pps_lost,
    output logic             o_resync,
    output logic [1:0]       o_state
);

    pps_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [NUM_W-1:0] r_rem;
    logic [NUM_W-1:0] r_idx;
    logic             r_trig;
    logic             r_stb;
    logic             r_resync;
    logic             r_lost;
    logic [WD_W-1:0]  r_wd;

    pps_state_t       w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_half_nx;
    logic [NUM_W-1:0] w_rem_nx;
    logic [NUM_W-1:0] w_idx_nx;
    logic             w_stb_nx;
    logic             w_resync_nx;
    logic             w_ext_edge;
    logic             w_int_edge;
    logic             w_edge;
    logic             w_cnt_done;
    logic [CNT_W-1:0] w_half_ld;

    pps_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sync  (i_sync),
        .o_edge  (w_ext_edge)
    );

    // a real edge always wins over a same-cycle holdover edge
    assign w_int_edge = i_holdover_en
                      && (i_timeout != '0)
                      && (r_wd == i_timeout - WD_W'(1))
                      && !w_ext_edge;
    assign w_edge     = w_ext_edge | w_int_edge;
    assign w_half_ld  = (i_half_period == '0) ? CNT_W'(1) : i_half_period;
    assign w_cnt_done = (r_cnt == r_half - CNT_W'(1));

    assign o_trig      = r_trig;
    assign o_trig_stb  = r_stb;
    assign o_pulse_idx = r_idx;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_pps_lost  = r_lost;
    assign o_resync    = r_resync;
    assign o_state     = r_state;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_half_nx   = r_half;
        w_rem_nx    = r_rem;
        w_idx_nx    = r_idx;
        w_stb_nx    = 1'b0;
        w_resync_nx = 1'b0;
        if (w_edge) begin
            w_half_nx   = w_half_ld;
            w_cnt_nx    = '0;
            w_resync_nx = (r_state != ST_IDLE);
            w_idx_nx    = '0;
            if (i_pulse_num != '0) begin
                w_state_nx = ST_HIGH;
                w_rem_nx   = i_pulse_num - NUM_W'(1);
                w_stb_nx   = 1'b1;
            end else begin
                w_state_nx = ST_IDLE;
                w_rem_nx   = '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nx = '0;
                end
                ST_HIGH: begin
                    if (w_cnt_done) begin
                        w_state_nx = ST_LOW;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (w_cnt_done) begin
                        w_cnt_nx = '0;
                        if (r_rem != '0) begin
                            w_state_nx = ST_HIGH;
                            w_rem_nx   = r_rem - NUM_W'(1);
                            w_idx_nx   = r_idx + NUM_W'(1);
                            w_stb_nx   = 1'b1;
                        end else begin
                            w_state_nx = ST_IDLE;
                            w_idx_nx   = '0;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_rem_nx   = '0;
                    w_idx_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_half   <= '0;
            r_rem    <= '0;
            r_idx    <= '0;
            r_trig   <= 1'b0;
            r_stb    <= 1'b0;
            r_resync <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_half   <= w_half_nx;
            r_rem    <= w_rem_nx;
            r_idx    <= w_idx_nx;
            r_trig   <= (w_state_nx == ST_HIGH);
            r_stb    <= w_stb_nx;
            r_resync <= w_resync_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd   <= '0;
            r_lost <= 1'b0;
        end else begin
            if (w_ext_edge) begin
                r_wd   <= '0;
                r_lost <= 1'b0;
            end else if (w_int_edge) begin
                r_wd   <= '0;
                r_lost <= 1'b1;
            end else if (r_wd != '1) begin
                r_wd <= r_wd + WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pps_pulse_gen.sv
// Directed bench for pps_pulse_gen: bursts, resync, holdover and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pps_pulse_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync;
    logic [15:0] pulse_num;
    logic [31:0] half_period;
    logic [31:0] timeout;
    logic        hold_en;
    logic        o_trig;
    logic        o_trig_stb;
    logic [15:0] o_pulse_idx;
    logic        o_busy;
    logic        o_pps_lost;
    logic        o_resync;
    logic [1:0]  o_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pps_pulse_gen dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sync        (sync),
        .i_pulse_num   (pulse_num),
        .i_half_period (half_period),
        .i_timeout     (timeout),
        .i_holdover_en (hold_en),
        .o_trig        (o_trig),
        .o_trig_stb    (o_trig_stb),
        .o_pulse_idx   (o_pulse_idx),
        .o_busy        (o_busy),
        .o_pps_lost    (o_pps_lost),
        .o_resync      (o_resync),
        .o_state       (o_state)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got),
                     $signed(exp));
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_busy(input int lim, output int cyc);
        cyc = 0;
        while (!o_busy && cyc < lim) begin
            tick();
            cyc++;
        end
        if (!o_busy) cyc = -1;
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (o_busy && k < lim) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_rise(input int lim, output int cyc);
        logic p;
        bit   found;
        p     = o_busy;
        cyc   = 0;
        found = 0;
        while (!found && cyc < lim) begin
            tick();
            cyc++;
            if (o_busy && !p) found = 1;
            p = o_busy;
        end
        if (!found) cyc = -1;
    endtask

    // called on the first busy sample of a burst of n pulses, half h
    task automatic measure(input string tag, input int n, input int h,
                           output int nres);
        int j, err, nstb, ph;
        j = 0; err = 0; nstb = 0; nres = 0;
        while (o_busy && j < 2000) begin
            ph = j % (2 * h);
            if (o_trig !== (ph < h)) err++;
            if (o_trig_stb !== (ph == 0)) err++;
            if (o_pulse_idx !== 16'(j / (2 * h))) err++;
            if (o_state !== ((ph < h) ? 2'd1 : 2'd2)) err++;
            nstb += int'(o_trig_stb);
            nres += int'(o_resync);
            tick();
            j++;
        end
        chk({tag, "_len"}, j, 2 * h * n);
        chk({tag, "_pattern_err"}, err, 0);
        chk({tag, "_stb_cnt"}, nstb, n);
        chk({tag, "_trig_after"}, o_trig, 0);
    endtask

    initial begin
        int c, k, nres, act;
        logic all_hi;

        rst_n = 0; sync = 0; pulse_num = 0; half_period = 0;
        timeout = 0; hold_en = 0;
        repeat (3) tick();
        chk("rst_trig", o_trig, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_state", o_state, 0);
        chk("rst_misc", {o_trig_stb, o_pps_lost, o_resync}, 0);
        chk("rst_idx", o_pulse_idx, 0);
        rst_n = 1;
        repeat (5) tick();

        // 3 pulses of 4 high / 4 low
        pulse_num = 3; half_period = 4;
        sync = 1;
        wait_busy(20, c);
        chk("a_latency", c, 4);
        sync = 0;
        measure("a", 3, 4, nres);
        chk("a_resync", nres, 0);
        repeat (5) tick();

        // zero pulses: nothing happens
        pulse_num = 0;
        sync = 1;
        act = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) sync = 0;
            act += int'(o_busy | o_trig | o_trig_stb | o_resync);
            tick();
        end
        chk("b_quiet", act, 0);
        chk("b_state", o_state, 0);

        // half period 0 behaves as 1
        pulse_num = 2; half_period = 0;
        sync = 1;
        wait_busy(20, c);
        chk("c_latency", c, 4);
        sync = 0;
        measure("c", 2, 1, nres);
        repeat (5) tick();

        // restart during pulse 1 of a 5-pulse burst
        pulse_num = 5; half_period = 4;
        sync = 1;
        wait_busy(20, c);
        sync = 0;
        k = 0;
        while (o_pulse_idx != 16'd1 && k < 50) begin
            tick();
            k++;
        end
        chk("d_reach_idx1", o_pulse_idx, 1);
        sync = 1;
        k = 0;
        all_hi = 1'b1;
        while (!o_resync && k < 10) begin
            all_hi &= o_trig;
            tick();
            k++;
        end
        sync = 0;
        chk("d_resync_lat", k, 4);
        chk("d_trig_held", all_hi & o_trig, 1);
        measure("d", 5, 4, nres);
        chk("d_resync_cnt", nres, 1);
        repeat (5) tick();

        // holdover every 100 cycles
        timeout = 100; hold_en = 1;
        pulse_num = 2; half_period = 3;
        sync = 1;
        wait_busy(20, c);
        sync = 0;
        chk("e_lost_init", o_pps_lost, 0);
        wait_rise(200, c);
        chk("e_period1", c, 100);
        chk("e_lost_set", o_pps_lost, 1);
        wait_rise(200, c);
        chk("e_period2", c, 100);
        sync = 1;
        k = 0;
        while (o_pps_lost && k < 10) begin
            tick();
            k++;
        end
        sync = 0;
        chk("e_lost_clr_lat", k, 4);

        // holdover disabled
        hold_en = 0;
        wait_idle(50);
        act = 0;
        for (int i = 0; i < 250; i++) begin
            act += int'(o_busy);
            tick();
        end
        chk("f_no_holdover", act, 0);

        // timeout 0 disables holdover even when enabled
        hold_en = 1; timeout = 0;
        sync = 1;
        wait_busy(20, c);
        sync = 0;
        wait_rise(250, c);
        chk("f_tmo0", c, -1);
        hold_en = 0;

        // async reset mid-HIGH, level held high across release
        pulse_num = 3; half_period = 10;
        repeat (3) tick();
        sync = 1;
        wait_busy(20, c);
        repeat (2) tick();
        chk("g_in_high", o_state, 1);
        #2 rst_n = 0;
        #1;
        chk("g_async_trig", o_trig, 0);
        chk("g_async_state", o_state, 0);
        chk("g_async_busy", {o_busy, o_trig_stb, o_pulse_idx}, 0);
        repeat (3) tick();
        rst_n = 1;
        act = 0;
        for (int i = 0; i < 40; i++) begin
            act += int'(o_busy | o_trig);
            tick();
        end
        chk("g_no_burst", act, 0);
        sync = 0;
        repeat (5) tick();
        sync = 1;
        wait_busy(20, c);
        chk("g_rearm", c, 4);
        sync = 0;
        wait_idle(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pps_pulse_gen.md
PPS_PULSE_GEN -- requirements
Module: pps_pulse_gen

Interface
REQ-001 Parameter CNT_W, default 32: width of the half-period counter and the i_half_period input.
REQ-002 Parameter NUM_W, default 16: width of the pulse-count input, the remaining-count register and o_pulse_idx.
REQ-003 Parameter SYNC_STAGES, default 2, min 2: depth of the i_sync synchroniser.
REQ-004 Parameter WD_W, default 32: width of the PPS watchdog counter and i_timeout.
REQ-005 Ports: i_clk in 1, the single clock; i_rst_n in 1, reset, asynchronous and active-low.
REQ-006 Ports: i_sync in 1, asynchronous PPS input.
REQ-007 Ports: i_pulse_num in NUM_W, pulses per PPS; i_half_period in CNT_W, half-period in clocks.
REQ-008 Ports: i_timeout in WD_W, clocks without an edge before holdover; i_holdover_en in 1, enables holdover.
REQ-009 Ports: o_trig out 1, pulse train; o_trig_stb out 1, one-cycle strobe at each o_trig rise.
REQ-010 Ports: o_pulse_idx out NUM_W, index of the current pulse, 0-based.
REQ-011 Ports: o_busy out 1, burst active; o_pps_lost out 1, holdover active; o_resync out 1, burst-aborted strobe; o_state out 2.

Function
REQ-012 i_sync SHALL pass through a SYNC_STAGES flop chain; the edge SHALL be sync_q & ~sync_q_d, one cycle wide, asserting SYNC_STAGES+1 cycles after the i_sync rise.
REQ-013 States SHALL be IDLE=0, HIGH=1, LOW=2; the encoding SHALL appear on o_state; code 3 SHALL return to IDLE.
REQ-014 On an edge, i_pulse_num and i_half_period SHALL be latched; a latched half-period of 0 SHALL be treated as 1.
REQ-015 Edge in IDLE with latched num>0: next state HIGH, remaining=num-1, o_pulse_idx=0.
REQ-016 Edge in IDLE with latched num=0: remain in IDLE with no output activity.
REQ-017 o_trig SHALL be registered, high exactly while in HIGH; HIGH and LOW SHALL each last exactly half_period cycles.
REQ-018 End of LOW: if remaining>0, go to HIGH, decrement remaining and increment o_pulse_idx; otherwise go to IDLE.
REQ-019 o_trig_stb SHALL be high for the first cycle of every HIGH.
REQ-020 An edge in HIGH or LOW SHALL restart the burst as in REQ-015; o_resync SHALL pulse for 1 cycle.
REQ-021 If that restart occurs in HIGH, o_trig SHALL stay high and o_trig_stb SHALL pulse.
REQ-022 The watchdog SHALL clear on every real edge and otherwise increment, saturating.
REQ-023 With i_holdover_en=1, a watchdog value equal to i_timeout-1 SHALL generate one internal edge, clear the watchdog and set o_pps_lost.
REQ-024 o_pps_lost SHALL clear on the next real edge, which SHALL take priority over a same-cycle internal edge.
REQ-025 With i_holdover_en=0, no internal edge SHALL be generated; i_timeout=0 SHALL disable holdover.
REQ-026 o_busy SHALL equal (state != IDLE).

Reset
REQ-027 Asserting i_rst_n low SHALL asynchronously force IDLE.
REQ-028 Reset SHALL zero all outputs, counters, the watchdog and the synchroniser, including mid-burst.
REQ-029 After release, the first edge requires a 0->1 transition of synchronised i_sync; a level held high through reset SHALL NOT trigger.

Structure
REQ-030 State encodings and the defaults of CNT_W, NUM_W and WD_W SHALL live in the shared package pps_pkg.
REQ-031 The synchroniser plus edge detector SHALL be the sub-module pps_edge_det, parametrised by SYNC_STAGES.

Verification
REQ-032 num=3, half=4, one i_sync rise: o_trig is high for 4 cycles and low for 4, three times; o_trig_stb fires 3 times; o_pulse_idx steps 0,1,2; o_busy drops after 24 cycles.
REQ-033 num=0, i_sync rise: o_trig and o_busy stay 0.
REQ-034 Second edge at pulse 1 of num=5: o_resync pulses once, o_pulse_idx returns to 0, and 5 full pulses follow.
REQ-035 Holdover with timeout=100, i_sync stopped: an internal burst starts every 100 cycles and o_pps_lost=1; the next real edge clears o_pps_lost.
REQ-036 i_rst_n low mid-HIGH: o_trig=0 immediately (asynchronous), state=IDLE; i_sync held high across release gives no burst.
REQ-037 half=0, num=2: pulses are 1 cycle high and 1 cycle low.
